// File: rtl/chess_clock_ctrl.sv
// Two-player BCD mm:ss chess clock: IDLE time editing, alternating run, pause, flag on timeout.
// Define FISCHER_INC_EN to build the turn-end increment of INC_SEC seconds (saturating at 99:59).
module chess_clock_ctrl #(
  parameter int CLK_HZ      = 100000000,
  parameter int DEFAULT_MIN = 5,
  parameter int INC_SEC     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       sw,
  input  logic       sel,
  input  logic       btn_p0,
  input  logic       btn_p1,
  input  logic       min_up,
  input  logic       sec_up,
  input  logic       min_dn,
  input  logic       sec_dn,
  output logic [3:0] disp_m2,
  output logic [3:0] disp_m1,
  output logic [3:0] disp_s2,
  output logic [3:0] disp_s1,
  output logic       active,
  output logic       running,
  output logic       flag0,
  output logic       flag1
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);
  // Out-of-range parameters fall back to a 00:00 start time rather than invalid BCD.
  localparam bit PARAMS_OK = (DEFAULT_MIN >= 0) && (DEFAULT_MIN <= 99) &&
                             (INC_SEC >= 0) && (INC_SEC <= 59);
  localparam logic [15:0] DEF_TIME = PARAMS_OK ?
    {4'(DEFAULT_MIN / 10), 4'(DEFAULT_MIN % 10), 8'h00} : 16'h0000;

  typedef enum logic [2:0] {IDLE, RUN_P0, RUN_P1, PAUSE, FLAG} state_t;

  state_t          state, stateNext;
  logic [15:0]     t0, t1, t0Next, t1Next;
  logic [15:0]     dispT;
  logic [PW-1:0]   presc, prescNext;
  logic            act, actNext;
  logic            flg0, flg1, flg0Next, flg1Next;
  logic [5:0]      prevLvl, btnLvl, btnPulse;
  logic            pBtn0, pBtn1, pMinUp, pSecUp, pMinDn, pSecDn;
  logic            tick, runner, timeUp;
  logic [15:0]     editT, runT;

  // Times are packed {m2, m1, s2, s1}, one BCD digit per nibble.
  function automatic logic [15:0] secUp(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[7:0] == 8'h59) r[7:0] = 8'h00;
    else if (t[3:0] == 4'd9) begin
      r[7:4] = t[7:4] + 4'd1;
      r[3:0] = 4'd0;
    end else r[3:0] = t[3:0] + 4'd1;
    return r;
  endfunction

  function automatic logic [15:0] secDn(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[7:0] == 8'h00) r[7:0] = 8'h59;
    else if (t[3:0] == 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else r[3:0] = t[3:0] - 4'd1;
    return r;
  endfunction

  function automatic logic [15:0] minUp(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[15:8] == 8'h99) r[15:8] = 8'h00;
    else if (t[11:8] == 4'd9) begin
      r[15:12] = t[15:12] + 4'd1;
      r[11:8]  = 4'd0;
    end else r[11:8] = t[11:8] + 4'd1;
    return r;
  endfunction

  function automatic logic [15:0] minDn(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[15:8] == 8'h00) r[15:8] = 8'h99;
    else if (t[11:8] == 4'd0) begin
      r[15:12] = t[15:12] - 4'd1;
      r[11:8]  = 4'd9;
    end else r[11:8] = t[11:8] - 4'd1;
    return r;
  endfunction

  // One-second countdown with borrow s1 -> s2 -> m1 -> m2; never called on 00:00.
  function automatic logic [15:0] tickDec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

`ifdef FISCHER_INC_EN
  localparam logic [7:0] INC8 = 8'(INC_SEC);

  function automatic logic [15:0] addInc(input logic [15:0] t);
    logic [7:0] secs, mins;
    secs = 8'(t[7:4]) * 8'd10 + 8'(t[3:0]) + INC8;
    mins = 8'(t[15:12]) * 8'd10 + 8'(t[11:8]);
    if (secs >= 8'd60) begin
      secs = secs - 8'd60;
      mins = mins + 8'd1;
    end
    if (mins > 8'd99) return 16'h9959;
    return {4'(mins / 8'd10), 4'(mins % 8'd10), 4'(secs / 8'd10), 4'(secs % 8'd10)};
  endfunction
`endif

  assign btnLvl   = {btn_p0, btn_p1, min_up, sec_up, min_dn, sec_dn};
  assign btnPulse = btnLvl & ~prevLvl;
  assign pBtn0    = btnPulse[5];
  assign pBtn1    = btnPulse[4];
  assign pMinUp   = btnPulse[3];
  assign pSecUp   = btnPulse[2];
  assign pMinDn   = btnPulse[1];
  assign pSecDn   = btnPulse[0];

  assign tick = ((state == RUN_P0) || (state == RUN_P1)) && (presc == PRESC_TOP);

  always_comb begin
    stateNext = state;
    t0Next    = t0;
    t1Next    = t1;
    actNext   = act;
    flg0Next  = flg0;
    flg1Next  = flg1;
    prescNext = '0;
    editT     = '0;
    runT      = '0;
    runner    = 1'b0;
    timeUp    = 1'b0;
    if (clr) begin
      stateNext = IDLE;
      t0Next    = DEF_TIME;
      t1Next    = DEF_TIME;
      actNext   = 1'b0;
      flg0Next  = 1'b0;
      flg1Next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          actNext = sel;
          editT   = sel ? t1 : t0;
          if (pSecUp) editT = secUp(editT);
          if (pSecDn) editT = secDn(editT);
          if (pMinUp) editT = minUp(editT);
          if (pMinDn) editT = minDn(editT);
          if (sel) t1Next = editT;
          else     t0Next = editT;
          if (sw && (pBtn0 || pBtn1)) begin
            // A press starts the opponent; P0's press wins a tie, so P1 runs.
            runner  = pBtn0;
            actNext = runner;
            runT    = runner ? t1Next : t0Next;
            if (runT == '0) begin
              stateNext = FLAG;
              if (runner) flg1Next = 1'b1;
              else        flg0Next = 1'b1;
            end else stateNext = runner ? RUN_P1 : RUN_P0;
          end
        end
        RUN_P0, RUN_P1: begin
          runner    = (state == RUN_P1);
          runT      = runner ? t1 : t0;
          prescNext = tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (runT == '0) timeUp = 1'b1;
            else begin
              runT   = tickDec(runT);
              timeUp = (runT == '0);
            end
          end
          if (timeUp) begin
            stateNext = FLAG;
            if (runner) flg1Next = 1'b1;
            else        flg0Next = 1'b1;
          end else if (!sw) begin
            stateNext = PAUSE;
          end else if (runner ? pBtn1 : pBtn0) begin
`ifdef FISCHER_INC_EN
            runT = addInc(runT);
`endif
            stateNext = runner ? RUN_P0 : RUN_P1;
            actNext   = ~runner;
            prescNext = '0;
          end
          if (runner) t1Next = runT;
          else        t0Next = runT;
        end
        PAUSE: begin
          if (sw) stateNext = act ? RUN_P1 : RUN_P0;
        end
        FLAG: begin
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      t0      <= DEF_TIME;
      t1      <= DEF_TIME;
      presc   <= '0;
      act     <= 1'b0;
      flg0    <= 1'b0;
      flg1    <= 1'b0;
      prevLvl <= '0;
      dispT   <= DEF_TIME;
    end else begin
      state   <= stateNext;
      t0      <= t0Next;
      t1      <= t1Next;
      presc   <= prescNext;
      act     <= actNext;
      flg0    <= flg0Next;
      flg1    <= flg1Next;
      prevLvl <= clr ? '0 : btnLvl;
      dispT   <= clr ? DEF_TIME : (((state == IDLE) ? sel : act) ? t1 : t0);
    end
  end

  assign disp_m2 = dispT[15:12];
  assign disp_m1 = dispT[11:8];
  assign disp_s2 = dispT[7:4];
  assign disp_s1 = dispT[3:0];
  assign active  = act;
  assign running = (state == RUN_P0) || (state == RUN_P1);
  assign flag0   = flg0;
  assign flag1   = flg1;

endmodule
